// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for if_id_queue: push side, pop side, redirect flush and occupancy.
interface if_id_queue_if #(
  parameter int DEPTH = 4
);
  logic                   flush;
  logic                   in_valid;
  logic [31:0]            in_pc;
  logic [31:0]            in_inst;
  logic                   in_ready;
  logic                   out_valid;
  logic [31:0]            out_pc;
  logic [31:0]            out_inst;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction FIFO with flush-on-redirect and a NOP head when empty.
// Optional zero-latency empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave q
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   NOP      = 32'h00000013;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          empty, full, push, pop, bypass, wr_en, rd_en;
  logic [63:0]   head;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == FULL_CNT);
  assign head       = mem[rd_ptr_reg];
  assign q.count    = count_reg;
  assign q.in_ready = !full && !q.flush && rst;

`ifdef IFQ_BYPASS_EN
  // Empty queue forwards the fetch pair straight to decode; rst gate keeps out_valid low in reset.
  assign bypass      = empty && q.in_valid && !q.flush && rst;
  assign q.out_valid = (!empty && !q.flush) || bypass;
`else
  assign bypass      = 1'b0;
  assign q.out_valid = !empty && !q.flush;
`endif

  assign push = q.in_valid && q.in_ready && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;

  // A bypassed pair taken by decode is never stored; a bypassed pair left waiting is stored normally.
  assign wr_en = push && !(bypass && q.out_ready);
  assign rd_en = pop && !bypass;

  always_comb begin
    q.out_pc   = 32'h0;
    q.out_inst = NOP;
    if (bypass) begin
      q.out_pc   = q.in_pc;
      q.out_inst = q.in_inst;
    end else if (q.out_valid) begin
      q.out_pc   = head[63:32];
      q.out_inst = head[31:0];
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (q.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_en) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_next = rd_ptr_reg + 1'b1;
      if (wr_en && !rd_en)      count_next = count_reg + 1'b1;
      else if (rd_en && !wr_en) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {q.in_pc, q.in_inst};
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: vector table for fill/drain plus hand sequences for
// reset, streaming, decode stall, flush, pointer wrap (scoreboard) and asynchronous reset.
module tb_if_id_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  if_id_queue_if #(.DEPTH(DEPTH)) q_if ();
  if_id_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(q_if));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
    q_if.in_valid  = iv;
    q_if.in_pc     = pc;
    q_if.in_inst   = inst;
    q_if.out_ready = ordy;
    q_if.flush     = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [31:0] e_pc, input logic [31:0] e_inst,
                              input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy; v.fl = 1'b0;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sb [$];
    logic [31:0] exp_pc;
    logic        ordy;
    int          sent;
    int          got;
    int          cyc;

    // Fill to full with decode stalled, then drain in order.
    vecs[0] = mk(1'b1, 32'd0, 32'hA0, 1'b0, 1'b1, BYP,  32'd0, BYP ? 32'hA0 : NOP, 3'd0);
    vecs[1] = mk(1'b1, 32'd1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'd0, 32'hA0, 3'd1);
    vecs[2] = mk(1'b1, 32'd2, 32'hA2, 1'b0, 1'b1, 1'b1, 32'd0, 32'hA0, 3'd2);
    vecs[3] = mk(1'b1, 32'd3, 32'hA3, 1'b0, 1'b1, 1'b1, 32'd0, 32'hA0, 3'd3);
    vecs[4] = mk(1'b1, 32'd4, 32'hA4, 1'b0, 1'b0, 1'b1, 32'd0, 32'hA0, 3'd4);
    vecs[5] = mk(1'b0, 32'd0, 32'h0,  1'b1, 1'b0, 1'b1, 32'd0, 32'hA0, 3'd4);
    vecs[6] = mk(1'b0, 32'd0, 32'h0,  1'b1, 1'b1, 1'b1, 32'd1, 32'hA1, 3'd3);
    vecs[7] = mk(1'b0, 32'd0, 32'h0,  1'b1, 1'b1, 1'b1, 32'd2, 32'hA2, 3'd2);
    vecs[8] = mk(1'b0, 32'd0, 32'h0,  1'b1, 1'b1, 1'b1, 32'd3, 32'hA3, 3'd1);
    vecs[9] = mk(1'b0, 32'd0, 32'h0,  1'b0, 1'b1, 1'b0, 32'd0, NOP,    3'd0);

    // Reset held with fetch presenting data.
    rst = 1'b0;
    drive(1'b1, 32'h55, 32'h66, 1'b1, 1'b0);
    #2;
    chk("rst_out_valid", 32'(q_if.out_valid), 32'd0);
    chk("rst_out_inst", q_if.out_inst, NOP);
    chk("rst_out_pc", q_if.out_pc, 32'd0);
    chk("rst_count", 32'(q_if.count), 32'd0);
    chk("rst_in_ready", 32'(q_if.in_ready), 32'd0);
    next_cycle();
    next_cycle();
    chk("rst_hold_count", 32'(q_if.count), 32'd0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rel_in_ready", 32'(q_if.in_ready), 32'd1);
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      $display("vec %0d: iv=%0b pc=%0d ordy=%0b -> ir=%0b ov=%0b out_pc=%0d cnt=%0d", i,
               vecs[i].iv, vecs[i].pc, vecs[i].ordy, q_if.in_ready, q_if.out_valid,
               q_if.out_pc, q_if.count);
      chk($sformatf("vec%0d_in_ready", i), 32'(q_if.in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(q_if.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out_pc", i), q_if.out_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_out_inst", i), q_if.out_inst, vecs[i].e_inst);
      chk($sformatf("vec%0d_count", i), 32'(q_if.count), 32'(vecs[i].e_cnt));
      next_cycle();
    end

    // Streaming: push and pop every cycle.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'(k), 32'h100 + 32'(k), 1'b1, 1'b0);
      @(negedge clk);
      $display("stream %0d: out_valid=%0b out_pc=%0d count=%0d", k, q_if.out_valid,
               q_if.out_pc, q_if.count);
      chk("stream_out_valid", 32'(q_if.out_valid), 32'(BYP || k > 0));
      exp_pc = BYP ? 32'(k) : (k == 0 ? 32'd0 : 32'(k - 1));
      chk("stream_out_pc", q_if.out_pc, exp_pc);
      chk("stream_out_inst", q_if.out_inst,
          (BYP || k > 0) ? 32'h100 + exp_pc : NOP);
      chk("stream_count", 32'(q_if.count), (BYP || k == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stream_tail_valid", 32'(q_if.out_valid), 32'(!BYP));
    chk("stream_tail_pc", q_if.out_pc, BYP ? 32'd0 : 32'd9);
    chk("stream_tail_count", 32'(q_if.count), BYP ? 32'd0 : 32'd1);
    next_cycle();

    // Decode stall while fetch keeps pushing.
    drive(1'b1, 32'd0, 32'hB0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_start_count", 32'(q_if.count), 32'd0);
    next_cycle();
    for (int s = 1; s <= 4; s++) begin
      drive(1'b1, 32'(s), 32'hB0 + 32'(s), 1'b0, 1'b0);
      @(negedge clk);
      $display("stall %0d: head pc=%0d inst=%h count=%0d", s, q_if.out_pc, q_if.out_inst,
               q_if.count);
      chk("stall_head_pc", q_if.out_pc, 32'd0);
      chk("stall_head_inst", q_if.out_inst, 32'hB0);
      chk("stall_count", 32'(q_if.count), 32'(s));
      next_cycle();
    end
    chk("stall_full_ready", 32'(q_if.in_ready), 32'd0);
    for (int d = 0; d < 4; d++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      $display("stall drain %0d: pc=%0d inst=%h", d, q_if.out_pc, q_if.out_inst);
      chk("stall_drain_pc", q_if.out_pc, 32'(d));
      chk("stall_drain_inst", q_if.out_inst, 32'hB0 + 32'(d));
      next_cycle();
    end

    // Flush with a simultaneous push.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_pre_count", 32'(q_if.count), 32'd0);
    for (int p = 10; p < 13; p++) begin
      drive(1'b1, 32'(p), 32'hC0 + 32'(p), 1'b0, 1'b0);
      next_cycle();
    end
    drive(1'b1, 32'd7, 32'hC7, 1'b1, 1'b1);
    @(negedge clk);
    $display("flush: count=%0d out_valid=%0b in_ready=%0b", q_if.count, q_if.out_valid,
             q_if.in_ready);
    chk("flush_count_before", 32'(q_if.count), 32'd3);
    chk("flush_out_valid", 32'(q_if.out_valid), 32'd0);
    chk("flush_in_ready", 32'(q_if.in_ready), 32'd0);
    chk("flush_out_inst", q_if.out_inst, NOP);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_flush_count", 32'(q_if.count), 32'd0);
    chk("post_flush_valid", 32'(q_if.out_valid), 32'd0);
    chk("post_flush_ready", 32'(q_if.in_ready), 32'd1);
    next_cycle();
    drive(1'b1, 32'd20, 32'hD20, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    $display("after flush: head pc=%0d count=%0d", q_if.out_pc, q_if.count);
    chk("redirect_head_valid", 32'(q_if.out_valid), 32'd1);
    chk("redirect_head_pc", q_if.out_pc, 32'd20);
    chk("redirect_head_inst", q_if.out_inst, 32'hD20);
    chk("redirect_count", 32'(q_if.count), 32'd1);
    next_cycle();

    // Pointer wrap under random decode stalls, checked by scoreboard.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 10 || sb.size() > 0) && cyc < 300) begin
      ordy = 1'($urandom_range(0, 1));
      drive(sent < 10, 32'h200 + 32'(sent), 32'h300 + 32'(sent), ordy, 1'b0);
      @(negedge clk);
      chk("wrap_count_le_depth", 32'(q_if.count <= 3'd4), 32'd1);
      if (q_if.in_valid && q_if.in_ready) begin
        sb.push_back(q_if.in_pc);
        sent++;
      end
      if (q_if.out_valid && q_if.out_ready) begin
        if (sb.size() == 0) begin
          chk("wrap_duplicate", q_if.out_pc, 32'hFFFF_FFFF);
        end else begin
          exp_pc = sb.pop_front();
          $display("wrap pop: pc=%h expected %h", q_if.out_pc, exp_pc);
          chk("wrap_order_pc", q_if.out_pc, exp_pc);
          chk("wrap_order_inst", q_if.out_inst, exp_pc + 32'h100);
        end
        got++;
      end
      next_cycle();
      cyc++;
    end
    chk("wrap_sent", 32'(sent), 32'd10);
    chk("wrap_got", 32'(got), 32'd10);
    chk("wrap_in_time", 32'(cyc < 300), 32'd1);

    // Asynchronous reset mid-operation drops entries without a clock edge.
    drive(1'b1, 32'd40, 32'hE0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 32'd41, 32'hE1, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("async_pre_count", 32'(q_if.count), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    $display("async reset: count=%0d out_valid=%0b in_ready=%0b", q_if.count,
             q_if.out_valid, q_if.in_ready);
    chk("async_count", 32'(q_if.count), 32'd0);
    chk("async_out_valid", 32'(q_if.out_valid), 32'd0);
    chk("async_in_ready", 32'(q_if.in_ready), 32'd0);
    chk("async_out_pc", q_if.out_pc, 32'd0);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("async_release_ready", 32'(q_if.in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
